// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow and a selectable registered or fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_full,
    output logic                  rd_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_AF   = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_AE   = (ADDR_WIDTH+1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Handshake: the write port is ready while !wr_full and the read port is valid
    // while !rd_empty; a transfer happens on an edge where request and ready/valid
    // are both high. A request without ready/valid only sets its sticky error flag.
    assign wr_full      = (count == CNT_FULL);
    assign rd_empty     = (count == '0);
    assign almost_full  = (count >= CNT_AF);
    assign almost_empty = (count <= CNT_AE);

    assign wr_accept = !reset && wr_en && !wr_full;
    assign rd_accept = !reset && rd_en && !rd_empty;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous accepted read and write leave occupancy unchanged.
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; rd_en only pops it.
            assign data_out = mem[rd_ptr];
        end else begin : g_registered
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_out <= '0;
                end else if (rd_accept) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three configurations (default registered, FWFT, 32-bit x 8)
// checked every cycle against a queue model, plus directed literal expectations.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  wr_en = '0;
    logic [2:0]  rd_en = '0;
    logic [31:0] din [3];

    logic [7:0]  dout0, dout1;
    logic [31:0] dout2;
    logic [4:0]  cnt0, cnt1;
    logic [3:0]  cnt2;
    logic [2:0]  full_v, empty_v, af_v, ae_v, ovf_v, udf_v;

    logic [31:0] dout_a [3];
    logic [31:0] cnt_a  [3];

    logic [31:0] exp_q [3][$];
    logic [31:0] exp_dout [3];
    logic [2:0]  exp_ovf, exp_udf;
    bit          model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo_param u_def (
        .clk(clk), .reset(reset), .wr_en(wr_en[0]), .data_in(din[0][7:0]), .rd_en(rd_en[0]),
        .data_out(dout0), .wr_full(full_v[0]), .rd_empty(empty_v[0]), .almost_full(af_v[0]),
        .almost_empty(ae_v[0]), .count(cnt0), .overflow(ovf_v[0]), .underflow(udf_v[0])
    );

    sync_fifo_param #(.FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .wr_en(wr_en[1]), .data_in(din[1][7:0]), .rd_en(rd_en[1]),
        .data_out(dout1), .wr_full(full_v[1]), .rd_empty(empty_v[1]), .almost_full(af_v[1]),
        .almost_empty(ae_v[1]), .count(cnt1), .overflow(ovf_v[1]), .underflow(udf_v[1])
    );

    sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(1)) u_wide (
        .clk(clk), .reset(reset), .wr_en(wr_en[2]), .data_in(din[2]), .rd_en(rd_en[2]),
        .data_out(dout2), .wr_full(full_v[2]), .rd_empty(empty_v[2]), .almost_full(af_v[2]),
        .almost_empty(ae_v[2]), .count(cnt2), .overflow(ovf_v[2]), .underflow(udf_v[2])
    );

    always_comb begin
        dout_a[0] = {24'b0, dout0};
        dout_a[1] = {24'b0, dout1};
        dout_a[2] = dout2;
        cnt_a[0]  = {27'b0, cnt0};
        cnt_a[1]  = {27'b0, cnt1};
        cnt_a[2]  = {28'b0, cnt2};
    end

    function automatic int depth_of(input int k);
        return (k == 2) ? 8 : 16;
    endfunction

    function automatic int af_of(input int k);
        return (k == 2) ? 6 : 14;
    endfunction

    function automatic int ae_of(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic bit fwft_of(input int k);
        return (k == 1);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Model: a FIFO is a queue; acceptance uses the pre-edge occupancy.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                exp_q[k].delete();
                exp_ovf[k]  = 1'b0;
                exp_udf[k]  = 1'b0;
                exp_dout[k] = '0;
            end else begin
                int  sz;
                bit  wa, ra;
                logic [31:0] popped;
                sz = exp_q[k].size();
                wa = wr_en[k] && (sz != depth_of(k));
                ra = rd_en[k] && (sz != 0);
                if (wr_en[k] && sz == depth_of(k)) exp_ovf[k] = 1'b1;
                if (rd_en[k] && sz == 0) exp_udf[k] = 1'b1;
                if (ra) begin
                    popped = exp_q[k].pop_front();
                    if (!fwft_of(k)) exp_dout[k] = popped;
                end
                if (wa) exp_q[k].push_back((k == 2) ? din[k] : (din[k] & 32'hFF));
            end
        end
        if (reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 3; k++) begin
                int sz;
                sz = exp_q[k].size();
                check("count", k, cnt_a[k], sz);
                check("wr_full", k, {31'b0, full_v[k]}, {31'b0, sz == depth_of(k)});
                check("rd_empty", k, {31'b0, empty_v[k]}, {31'b0, sz == 0});
                check("almost_full", k, {31'b0, af_v[k]}, {31'b0, sz >= af_of(k)});
                check("almost_empty", k, {31'b0, ae_v[k]}, {31'b0, sz <= ae_of(k)});
                check("overflow", k, {31'b0, ovf_v[k]}, {31'b0, exp_ovf[k]});
                check("underflow", k, {31'b0, udf_v[k]}, {31'b0, exp_udf[k]});
                if (!fwft_of(k)) check("data_out", k, dout_a[k], exp_dout[k]);
                else if (sz > 0) check("data_out", k, dout_a[k], exp_q[k][0]);
            end
        end
    end

    // Drive one port for one edge, then return #1 after that edge.
    task automatic step(input int k, input bit w, input bit r, input logic [31:0] d);
        wr_en[k] = w;
        rd_en[k] = r;
        din[k]   = d;
        @(posedge clk);
        #1;
        wr_en[k] = 1'b0;
        rd_en[k] = 1'b0;
    endtask

    task automatic do_reset(input bit w0);
        reset    = 1'b1;
        wr_en[0] = w0;
        din[0]   = 32'h77;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wr_en[0] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) din[k] = '0;
        do_reset(1'b0);

        check("rst_count", 0, {27'b0, cnt0}, 32'd0);
        check("rst_empty", 0, {31'b0, empty_v[0]}, 32'd1);
        check("rst_full", 0, {31'b0, full_v[0]}, 32'd0);
        check("rst_ae", 0, {31'b0, ae_v[0]}, 32'd1);
        check("rst_af", 0, {31'b0, af_v[0]}, 32'd0);
        check("rst_dout", 0, {24'b0, dout0}, 32'd0);

        // Fill 16 words, then one write too many.
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b1, 1'b0, i);
            check("fill_af", 0, {31'b0, af_v[0]}, {31'b0, (i + 1) >= 14});
        end
        check("fill_count", 0, {27'b0, cnt0}, 32'd16);
        check("fill_full", 0, {31'b0, full_v[0]}, 32'd1);
        step(0, 1'b1, 1'b0, 32'h3C);
        check("ovf_set", 0, {31'b0, ovf_v[0]}, 32'd1);
        check("ovf_count", 0, {27'b0, cnt0}, 32'd16);

        // Drain with one-cycle registered read latency.
        for (int i = 0; i < 16; i++) begin
            step(0, 1'b0, 1'b1, 0);
            check("drain_data", 0, {24'b0, dout0}, i);
        end
        check("drain_empty", 0, {31'b0, empty_v[0]}, 32'd1);
        step(0, 1'b0, 1'b1, 0);
        check("udf_set", 0, {31'b0, udf_v[0]}, 32'd1);
        check("udf_dout_hold", 0, {24'b0, dout0}, 32'h0F);

        // Fill to 9, then reset with a concurrent write.
        for (int i = 0; i < 9; i++) step(0, 1'b1, 1'b0, 32'h80 + i);
        check("pre_rst_count", 0, {27'b0, cnt0}, 32'd9);
        do_reset(1'b1);
        check("midrst_count", 0, {27'b0, cnt0}, 32'd0);
        check("midrst_empty", 0, {31'b0, empty_v[0]}, 32'd1);
        check("midrst_ovf", 0, {31'b0, ovf_v[0]}, 32'd0);
        check("midrst_udf", 0, {31'b0, udf_v[0]}, 32'd0);
        step(0, 1'b1, 1'b0, 32'h11);
        step(0, 1'b0, 1'b1, 0);
        check("midrst_nostore", 0, {24'b0, dout0}, 32'h11);
        check("midrst_empty2", 0, {31'b0, empty_v[0]}, 32'd1);

        // Steady state at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 32'h20 + i);
        for (int i = 0; i < 40; i++) begin
            step(0, 1'b1, 1'b1, 32'h25 + i);
            check("conc_count", 0, {27'b0, cnt0}, 32'd5);
            check("conc_data", 0, {24'b0, dout0}, 32'h20 + i);
        end

        // First-word fall-through.
        step(1, 1'b1, 1'b0, 32'hA5);
        check("fwft_data", 1, {24'b0, dout1}, 32'hA5);
        check("fwft_nonempty", 1, {31'b0, empty_v[1]}, 32'd0);
        step(1, 1'b0, 1'b1, 0);
        check("fwft_pop_empty", 1, {31'b0, empty_v[1]}, 32'd1);
        step(1, 1'b1, 1'b0, 32'h5A);
        step(1, 1'b1, 1'b0, 32'hC3);
        check("fwft_head", 1, {24'b0, dout1}, 32'h5A);
        step(1, 1'b0, 1'b1, 0);
        check("fwft_next", 1, {24'b0, dout1}, 32'hC3);

        // 32-bit x 8 configuration with custom thresholds.
        for (int i = 0; i < 8; i++) begin
            step(2, 1'b1, 1'b0, 32'hDEADBEEF + i * 32'h01010101);
            check("wide_ae", 2, {31'b0, ae_v[2]}, {31'b0, (i + 1) <= 1});
            check("wide_af", 2, {31'b0, af_v[2]}, {31'b0, (i + 1) >= 6});
            check("wide_full", 2, {31'b0, full_v[2]}, {31'b0, (i + 1) == 8});
        end
        for (int i = 0; i < 8; i++) begin
            step(2, 1'b0, 1'b1, 0);
            check("wide_data", 2, dout2, 32'hDEADBEEF + i * 32'h01010101);
        end
        check("wide_empty", 2, {31'b0, empty_v[2]}, 32'd1);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO that succeeds the fixed 8-bit FIFO in the design, generalised in data width and depth. It adds programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between same-clock producer and consumer stages wherever rate smoothing is needed without a clock-domain crossing.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- clk  input  1  single clock; all logic on its rising edge
- reset  input  1  synchronous, active-high
- wr_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- rd_en  input  1  read/pop request
- data_out  output  DATA_WIDTH  read data
- wr_full  output  1  count == DEPTH
- rd_empty  output  1  count == 0
- almost_full  output  1  count >= AF_THRESH
- almost_empty  output  1  count <= AE_THRESH
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; write attempted while full
- underflow  output  1  sticky; read attempted while empty

## Operation
- Storage: DEPTH x DATA_WIDTH array. Write pointer and read pointer are each ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count is a registered counter, ADDR_WIDTH+1 bits wide, with no separate wrap bit. All four status flags are decoded combinationally from the registered count.
- A write is accepted iff wr_en && !wr_full. An accepted write stores data_in at wr_ptr and increments wr_ptr.
- A read is accepted iff rd_en && !rd_empty. An accepted read increments rd_ptr.
- Flags are sampled pre-edge. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- count update rule: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- overflow sets on wr_en && wr_full. underflow sets on rd_en && rd_empty. Both hold until reset. A rejected access leaves memory, pointers and count untouched.
- FWFT=0 (registered read): data_out loads mem[rd_ptr] on an accepted read and otherwise holds its last value.
- FWFT=1 (first-word-fall-through): data_out = mem[rd_ptr] continuously. It is valid whenever !rd_empty, and rd_en acts as a pop/acknowledge. Content while rd_empty is don't-care.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, data_out=0 (FWFT=0 register).
- Resulting flags after reset: rd_empty=1, wr_full=0, almost_full=0, almost_empty=1.
- Memory contents are not reset.
- Reset mid-operation: the next cycle is empty and all stored data is discarded. wr_en and rd_en are ignored in any cycle where reset=1.
- Parameter legality: 1 <= AE_THRESH < AF_THRESH <= DEPTH. Violations are a configuration error and are not checked in RTL.

## Timing
- Write accepted at edge N: count, rd_empty and almost_* reflect it after edge N.
- FWFT=1: the written word appears on data_out after edge N, so the first word is readable in cycle N+1.
- FWFT=0: read accepted at edge N means data_out is valid after edge N, i.e. 1-cycle read latency. count decrements at the same edge.
- Full to not-full, and empty to not-empty, each take effect one edge after the causing access. Back-to-back accesses every cycle are supported at 1 word/clk per port.
- Simultaneous accepted read and write at any occupancy 0<count<DEPTH: count is unchanged, both pointers advance, and no flag changes.

## Test plan
- Reset, then 16 writes of 0x00..0x0F (defaults): wr_full=1 after the 16th edge, count=16, almost_full=1 from count=14. A 17th write sets overflow=1 and leaves count=16.
- Drain the full FIFO with FWFT=0: data_out sequence 0x00..0x0F, each valid one cycle after rd_en. rd_empty=1 after the 16th read. One extra rd_en sets underflow=1.
- Concurrent rd_en and wr_en for 40 cycles at count=5, writing an incrementing pattern: count stays 5 throughout. Read data is in order across pointer wrap-around (beyond index 15).
- FWFT=1, write 0xA5 into an empty FIFO: data_out=0xA5 and rd_empty=0 in the next cycle with no rd_en. One rd_en returns rd_empty=1.
- Fill to 9, assert reset for 1 cycle with wr_en=1: count=0, rd_empty=1, overflow=0 and underflow=0. The write during reset is not stored.
- DATA_WIDTH=32, ADDR_WIDTH=3, AF_THRESH=6, AE_THRESH=1: almost_empty deasserts at count=2, almost_full asserts at count=6, wr_full at count=8. Data integrity of 0xDEADBEEF-style words is preserved.
